// File: rtl/my_sys_mem_test_master_if.sv
// Avalon-MM link between the memory test master and on-chip RAM slave s1.
// Ports: address/chipselect/clken/write/writedata/byteenable (master -> RAM),
//        readdata (RAM -> master, valid one cycle after a read strobe).
interface my_sys_mem_test_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                clken;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, chipselect, clken, write, writedata, byteenable,
    input  readdata
  );

  modport slave (
    input  address, chipselect, clken, write, writedata, byteenable,
    output readdata
  );
endinterface

// File: rtl/my_sys_mem_test_master.sv
// Memory self-test master: writes seed+i to base..base+N-1, reads back, counts mismatches.
// Latency: done pulses 2N+2 cycles after the accepted start (1 cycle when N=0).
// Backpressure: none; s1 has no waitrequest, so one access per cycle; start ignored unless idle.
// Ports: clk, reset_n (async active-low); start/base_addr/word_count/seed sampled with start;
//        busy/done/pass/err_count/first_err_addr status; mem = Avalon-MM master to RAM.
module my_sys_mem_test_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          word_count,
  input  logic [DATA_W-1:0]        seed,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ADDR_W:0]          err_count,
  output logic [ADDR_W-1:0]        first_err_addr,
  my_sys_mem_test_master_if.master mem
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] MAX_N = ONE << ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;       // index of the access currently on the bus
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DATA_W-1:0]   exp_q, exp_d;       // pattern word for the read on the bus
  logic                cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic                chipselect_q, chipselect_d;
  logic                write_q, write_d;
  logic                busy_d, done_d, pass_d;
  logic [ADDR_W:0]     err_d;
  logic [ADDR_W-1:0]   first_d;
  logic [ADDR_W:0]     n_req;
  logic                last;

  assign mem.address    = address_q;
  assign mem.chipselect = chipselect_q;
  assign mem.clken      = busy;
  assign mem.write      = write_q;
  assign mem.writedata  = writedata_q;
  assign mem.byteenable = '1;

  assign n_req = (word_count > MAX_N) ? MAX_N : word_count;
  assign last  = (idx_q == n_q - ONE);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_d          = n_q;
    base_d       = base_q;
    seed_d       = seed_q;
    exp_d        = exp_q;
    cmp_vld_d    = 1'b0;
    cmp_exp_d    = cmp_exp_q;
    cmp_addr_d   = cmp_addr_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    chipselect_d = chipselect_q;
    write_d      = write_q;
    busy_d       = busy;
    done_d       = 1'b0;
    pass_d       = pass;
    err_d        = err_count;
    first_d      = first_err_addr;

    // readdata belongs to the read strobed in the previous cycle
    if (cmp_vld_q && (mem.readdata != cmp_exp_q)) begin
      err_d = err_count + ONE;
      if (err_count == '0) first_d = cmp_addr_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_req;
          base_d  = base_addr;
          seed_d  = seed;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          if (n_req == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d      = WRITE;
            idx_d        = '0;
            address_d    = base_addr;
            writedata_d  = seed;
            chipselect_d = 1'b1;
            write_d      = 1'b1;
            busy_d       = 1'b1;
          end
        end
      end
      WRITE: begin
        if (last) begin
          state_d   = READ;
          idx_d     = '0;
          address_d = base_q;
          exp_d     = seed_q;
          write_d   = 1'b0;
        end else begin
          idx_d       = idx_q + ONE;
          address_d   = address_q + ADDR_W'(1);
          writedata_d = writedata_q + DATA_W'(1);
        end
      end
      READ: begin
        cmp_vld_d  = 1'b1;
        cmp_exp_d  = exp_q;
        cmp_addr_d = address_q;
        if (last) begin
          state_d      = DRAIN;
          chipselect_d = 1'b0;
        end else begin
          idx_d     = idx_q + ONE;
          address_d = address_q + ADDR_W'(1);
          exp_d     = exp_q + DATA_W'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      n_q            <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      exp_q          <= '0;
      cmp_vld_q      <= 1'b0;
      cmp_exp_q      <= '0;
      cmp_addr_q     <= '0;
      address_q      <= '0;
      writedata_q    <= '0;
      chipselect_q   <= 1'b0;
      write_q        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      n_q            <= n_d;
      base_q         <= base_d;
      seed_q         <= seed_d;
      exp_q          <= exp_d;
      cmp_vld_q      <= cmp_vld_d;
      cmp_exp_q      <= cmp_exp_d;
      cmp_addr_q     <= cmp_addr_d;
      address_q      <= address_d;
      writedata_q    <= writedata_d;
      chipselect_q   <= chipselect_d;
      write_q        <= write_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      first_err_addr <= first_d;
    end
  end

endmodule

// File: tb/tb_my_sys_mem_test_master.sv
// Bench for my_sys_mem_test_master: 256-word RAM model with read-bit-flip fault injection,
// expected writes/reads/results queued at start, checked by an independent monitor.
module tb_my_sys_mem_test_master;
  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    int          cyc;
    bit          pass;
    logic [8:0]  errs;
    logic [7:0]  first;
  } res_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  my_sys_mem_test_master_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  my_sys_mem_test_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .mem            (mem_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read latency 1; reads of flagged addresses return bit 0 inverted
  logic [DW-1:0] ram [256];
  bit            flip [256];
  always @(posedge clk) begin
    if (mem_if.chipselect && mem_if.clken) begin
      if (mem_if.write) ram[mem_if.address] <= mem_if.writedata;
      else mem_if.readdata <= ram[mem_if.address] ^ DW'(flip[mem_if.address]);
    end
  end

  acc_t wq[$];
  acc_t rq[$];
  res_t resq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  // monitor: pops and compares whenever the DUT presents an access or a done pulse
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_if.chipselect && mem_if.write) begin
        if (wq.size() == 0) fail_event("unexpected_write");
        else begin
          acc_t a;
          a = wq.pop_front();
          check("write", 128'({32'(cyc), mem_if.address, mem_if.writedata, busy, mem_if.clken, mem_if.byteenable}),
                         128'({32'(a.cyc), a.addr, a.data, 1'b1, 1'b1, 4'hF}));
        end
      end
      if (mem_if.chipselect && !mem_if.write) begin
        if (rq.size() == 0) fail_event("unexpected_read");
        else begin
          acc_t a;
          a = rq.pop_front();
          check("read", 128'({32'(cyc), mem_if.address, busy, mem_if.clken, mem_if.byteenable}),
                        128'({32'(a.cyc), a.addr, 1'b1, 1'b1, 4'hF}));
        end
      end
      if (done) begin
        if (resq.size() == 0) fail_event("unexpected_done");
        else begin
          res_t r;
          r = resq.pop_front();
          check("done", 128'({32'(cyc), pass, err_count, first_err_addr, busy, mem_if.chipselect}),
                        128'({32'(r.cyc), r.pass, r.errs, r.first, 1'b0, 1'b0}));
        end
      end
    end
  end

  // reference: pattern, addresses and result derived from plain arithmetic over the flip map
  task automatic issue(input logic [7:0] b, input int n, input logic [31:0] s,
                       output int c0, output int neff, output res_t r);
    @(negedge clk);
    base_addr  = b;
    word_count = 9'(n);
    seed       = s;
    start      = 1'b1;
    c0         = cyc;
    neff       = (n > 256) ? 256 : n;
    r.errs     = '0;
    r.first    = '0;
    for (int i = 0; i < neff; i++) begin
      logic [7:0] a;
      a = 8'(int'(b) + i);
      wq.push_back('{c0 + 1 + i, a, 32'(s + 32'(i))});
      rq.push_back('{c0 + neff + 1 + i, a, 32'(0)});
      if (flip[a]) begin
        if (r.errs == 0) r.first = a;
        r.errs = r.errs + 9'd1;
      end
    end
    r.pass = (r.errs == 0);
    r.cyc  = (neff == 0) ? c0 + 1 : c0 + 2 * neff + 2;
    resq.push_back(r);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic junk_start();
    start      = 1'b1;
    base_addr  = 8'($urandom);
    word_count = 9'($urandom_range(1, 300));
    seed       = $urandom;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [7:0] b, input int n, input logic [31:0] s, input bit extra);
    int   c0, neff, t;
    res_t r;
    issue(b, n, s, c0, neff, r);
    if (extra && neff >= 2) begin
      while (cyc < c0 + 2) @(negedge clk);
      junk_start();
      while (cyc < c0 + neff + 2) @(negedge clk);
      junk_start();
    end
    t = 0;
    while (resq.size() != 0 && t < 2 * neff + 20) begin
      @(negedge clk);
      t++;
    end
    if (resq.size() != 0) begin
      fail_event("done_timeout");
      wq.delete(); rq.delete(); resq.delete();
    end
    @(negedge clk);
    check("result_held", 128'({pass, err_count, first_err_addr}), 128'({r.pass, r.errs, r.first}));
  endtask

  task automatic clear_flips();
    for (int i = 0; i < 256; i++) flip[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c0, neff;
    res_t r;
    clear_flips();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 128'({busy, done, pass, mem_if.chipselect, mem_if.write, mem_if.clken,
                               err_count, first_err_addr, mem_if.address, mem_if.writedata, mem_if.byteenable}),
                         128'({6'b0, 9'd0, 8'd0, 8'd0, 32'd0, 4'hF}));
    reset_n = 1'b1;

    run(8'h10, 4, 32'hA5A5_0000, 1'b0);
    run(8'hFE, 4, $urandom, 1'b0);
    flip[8'h21] = 1'b1;
    flip[8'h23] = 1'b1;
    run(8'h20, 8, $urandom, 1'b0);
    clear_flips();
    run(8'h33, 0, $urandom, 1'b0);
    run(8'h37, 300, $urandom, 1'b0);
    run(8'h50, 12, $urandom, 1'b1);

    // async reset in the middle of the read phase after two mismatches
    flip[8'h40] = 1'b1;
    flip[8'h41] = 1'b1;
    issue(8'h40, 16, $urandom, c0, neff, r);
    while (cyc < c0 + 21) @(negedge clk);
    check("pre_reset_errs", 128'(err_count), 128'(9'd2));
    #2 reset_n = 1'b0;
    #1 check("async_reset", 128'({mem_if.chipselect, busy, done, err_count, mem_if.clken}),
                            128'({3'b0, 9'd0, 1'b0}));
    wq.delete(); rq.delete(); resq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    clear_flips();
    run(8'h40, 16, $urandom, 1'b0);

    for (int k = 0; k < 12; k++) begin
      int nf;
      clear_flips();
      nf = $urandom_range(0, 3);
      for (int j = 0; j < nf; j++) flip[$urandom_range(0, 255)] = 1'b1;
      run(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 40),
          $urandom, 1'($urandom));
    end

    repeat (5) @(negedge clk);
    check("write_queue_drained", 128'(wq.size()), 128'(0));
    check("read_queue_drained", 128'(rq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
